// File: rtl/ysyx_22041752_icache_refill_rsp_if.sv
// Refill-responder bus bundle: cache-facing sram_* line port plus the
// pipelined request/grant beat port toward main memory.
//   slave  : responder view (answers sram_*, drives mem_req/mem_addr)
//   master : environment view (cache drives sram_req, memory drives mem_gnt/mem_rvalid)
interface ysyx_22041752_icache_refill_rsp_if #(
  parameter int unsigned ADDR_WD = 32,
  parameter int unsigned DATA_WD = 64
) ();
  logic               sram_req;
  logic               sram_ready;
  logic [ADDR_WD-1:0] sram_addr;
  logic [DATA_WD-1:0] sram_rdata;
  logic               sram_valid;
  logic               mem_req;
  logic               mem_gnt;
  logic [ADDR_WD-1:0] mem_addr;
  logic               mem_rvalid;
  logic [DATA_WD-1:0] mem_rdata;

  modport slave (
    input  sram_req, sram_addr, mem_gnt, mem_rvalid, mem_rdata,
    output sram_ready, sram_rdata, sram_valid, mem_req, mem_addr
  );

  modport master (
    output sram_req, sram_addr, mem_gnt, mem_rvalid, mem_rdata,
    input  sram_ready, sram_rdata, sram_valid, mem_req, mem_addr
  );
endinterface

// File: rtl/ysyx_22041752_icache_refill_rsp.sv
// ICACHE refill responder: accepts one line request on the sram_* port,
// issues BEATS beat reads on the request/grant memory port and streams the
// returned beats back to the cache as single-cycle sram_valid pulses.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset
//   bus    - slave modport of the refill interface (sram_* and mem_* signals)
// All bus outputs are registered.
module ysyx_22041752_icache_refill_rsp #(
  parameter int unsigned ADDR_WD    = 32,
  parameter int unsigned DATA_WD    = 64,
  parameter int unsigned LINE_BYTES = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  ysyx_22041752_icache_refill_rsp_if.slave bus
);

  localparam int unsigned BEATS      = LINE_BYTES * 8 / DATA_WD;
  localparam int unsigned BEAT_BYTES = DATA_WD / 8;
  localparam int unsigned CNT_WD     = $clog2(BEATS) + 1;

  localparam logic [CNT_WD-1:0]  LAST_BEAT = CNT_WD'(BEATS - 1);
  localparam logic [ADDR_WD-1:0] LINE_MASK = ~ADDR_WD'(LINE_BYTES - 1);
  localparam logic [ADDR_WD-1:0] BEAT_STEP = ADDR_WD'(BEAT_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e             state_q,      state_d;
  logic [ADDR_WD-1:0] base_q,       base_d;
  logic [CNT_WD-1:0]  issue_cnt_q,  issue_cnt_d;
  logic [CNT_WD-1:0]  resp_cnt_q,   resp_cnt_d;
  logic               sram_ready_q, sram_ready_d;
  logic               sram_valid_q, sram_valid_d;
  logic [DATA_WD-1:0] sram_rdata_q, sram_rdata_d;
  logic               mem_req_q,    mem_req_d;
  logic [ADDR_WD-1:0] mem_addr_q,   mem_addr_d;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      base_q       <= '0;
      issue_cnt_q  <= '0;
      resp_cnt_q   <= '0;
      sram_ready_q <= 1'b1;
      sram_valid_q <= 1'b0;
      sram_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      issue_cnt_q  <= issue_cnt_d;
      resp_cnt_q   <= resp_cnt_d;
      sram_ready_q <= sram_ready_d;
      sram_valid_q <= sram_valid_d;
      sram_rdata_q <= sram_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    issue_cnt_d  = issue_cnt_q;
    resp_cnt_d   = resp_cnt_q;
    sram_ready_d = sram_ready_q;
    sram_valid_d = 1'b0;
    sram_rdata_d = sram_rdata_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;

    // Issue side: one beat address per grant, held until granted
    case (state_q)
      IDLE: begin
        if (bus.sram_req && sram_ready_q) begin
          base_d       = bus.sram_addr & LINE_MASK;
          issue_cnt_d  = '0;
          resp_cnt_d   = '0;
          sram_ready_d = 1'b0;
          mem_req_d    = 1'b1;
          mem_addr_d   = bus.sram_addr & LINE_MASK;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_gnt) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LAST_BEAT) begin
            mem_req_d = 1'b0;
            state_d   = WAIT;
          end else begin
            mem_addr_d = base_q + ADDR_WD'(issue_cnt_q + 1'b1) * BEAT_STEP;
          end
        end
      end
      WAIT: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Response side: counted independently; responses in IDLE are stray and dropped
    if (state_q != IDLE && bus.mem_rvalid) begin
      sram_valid_d = 1'b1;
      sram_rdata_d = bus.mem_rdata;
      resp_cnt_d   = resp_cnt_q + 1'b1;
      if (resp_cnt_q == LAST_BEAT) begin
        state_d      = IDLE;
        sram_ready_d = 1'b1;
        mem_req_d    = 1'b0;
      end
    end
  end

  assign bus.sram_ready = sram_ready_q;
  assign bus.sram_valid = sram_valid_q;
  assign bus.sram_rdata = sram_rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_ysyx_22041752_icache_refill_rsp.sv
// Directed bench for the ICACHE refill responder with a behavioural
// request/grant memory and scoreboards for beat addresses and beat data.
module tb_ysyx_22041752_icache_refill_rsp;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam logic [63:0] NONE = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int stall = 0;
  int rdly  = 0;
  int vcnt  = 0;

  rsp_t          pend[$];
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];

  ysyx_22041752_icache_refill_rsp_if #(.ADDR_WD(AW), .DATA_WD(DW)) bus ();

  ysyx_22041752_icache_refill_rsp #(
    .ADDR_WD(AW), .DATA_WD(DW), .LINE_BYTES(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] data_for(input logic [AW-1:0] a);
    if (a == 32'h8000_0000) return 64'h1111;
    if (a == 32'h8000_0008) return 64'h2222;
    return {a, ~a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one line request in the current cycle; expectations are queued here
  task automatic send(input logic [AW-1:0] a);
    logic [AW-1:0] b;
    b = a & ~32'hF;
    check("sram_ready_at_req", 64'(bus.sram_ready), 64'd1);
    bus.sram_req  = 1'b1;
    bus.sram_addr = a;
    for (int i = 0; i < 2; i++) begin
      exp_addr.push_back(b + 32'(i * 8));
      exp_data.push_back(data_for(b + 32'(i * 8)));
    end
    tick();
    bus.sram_req  = 1'b0;
    bus.sram_addr = '0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(exp_data.size() == 0 && bus.sram_ready) && n < 60) begin
      tick();
      n++;
    end
    check(tag, 64'(n < 60), 64'd1);
  endtask

  // Memory model: grants follow mem_req unless stalled, data returns in order
  initial begin
    rsp_t r;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.mem_rvalid = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        r = pend.pop_front();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = r.data;
      end
      if (bus.mem_req && stall > 0) begin
        bus.mem_gnt = 1'b0;
        stall--;
      end else begin
        bus.mem_gnt = bus.mem_req;
      end
    end
  end

  // Monitor: beat addresses at grant, beat data at sram_valid
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!reset && bus.mem_req && bus.mem_gnt) begin
        e = (exp_addr.size() > 0) ? 64'(exp_addr.pop_front()) : NONE;
        check("mem_addr_granted", 64'(bus.mem_addr), e);
        pend.push_back('{data_for(bus.mem_addr), cyc + 1 + rdly});
      end
      if (bus.sram_valid) begin
        vcnt++;
        e = (exp_data.size() > 0) ? exp_data.pop_front() : NONE;
        check("sram_rdata_beat", bus.sram_rdata, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset         = 1'b1;
    bus.sram_req  = 1'b0;
    bus.sram_addr = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    check("rst_sram_ready", 64'(bus.sram_ready), 64'd1);
    check("rst_sram_valid", 64'(bus.sram_valid), 64'd0);
    check("rst_sram_rdata", bus.sram_rdata, 64'd0);
    check("rst_mem_req",    64'(bus.mem_req), 64'd0);
    check("rst_mem_addr",   64'(bus.mem_addr), 64'd0);
    reset = 1'b0;
    tick();

    // Single refill, zero-wait memory
    vcnt = 0;
    send(32'h8000_0004);
    check("t1_mem_req_t1",    64'(bus.mem_req), 64'd1);
    check("t1_mem_addr_t1",   64'(bus.mem_addr), 64'h8000_0000);
    check("t1_ready_t1",      64'(bus.sram_ready), 64'd0);
    tick();
    check("t1_mem_req_t2",    64'(bus.mem_req), 64'd1);
    check("t1_mem_addr_t2",   64'(bus.mem_addr), 64'h8000_0008);
    check("t1_valid_t2",      64'(bus.sram_valid), 64'd0);
    tick();
    check("t1_valid_t3",      64'(bus.sram_valid), 64'd1);
    check("t1_rdata_t3",      bus.sram_rdata, 64'h1111);
    check("t1_ready_t3",      64'(bus.sram_ready), 64'd0);
    check("t1_mem_req_t3",    64'(bus.mem_req), 64'd0);
    tick();
    check("t1_valid_t4",      64'(bus.sram_valid), 64'd1);
    check("t1_rdata_t4",      bus.sram_rdata, 64'h2222);
    check("t1_ready_t4",      64'(bus.sram_ready), 64'd1);
    tick();
    check("t1_valid_t5",      64'(bus.sram_valid), 64'd0);
    check("t1_rdata_hold",    bus.sram_rdata, 64'h2222);
    check("t1_pulses",        64'(vcnt), 64'd2);

    // Grant stall: request and address held for 5 cycles
    vcnt  = 0;
    stall = 5;
    send(32'h8000_0000);
    for (int i = 0; i < 5; i++) begin
      check("t2_mem_req_stall",  64'(bus.mem_req), 64'd1);
      check("t2_mem_addr_stall", 64'(bus.mem_addr), 64'h8000_0000);
      check("t2_ready_stall",    64'(bus.sram_ready), 64'd0);
      tick();
    end
    wait_idle("t2_done");
    tick();
    check("t2_pulses", 64'(vcnt), 64'd2);

    // Overlap: beat 0 response coincides with beat 1 grant
    vcnt = 0;
    send(32'h8000_0040);
    tick();
    check("t3_mem_addr_beat1", 64'(bus.mem_addr), 64'h8000_0048);
    wait_idle("t3_done");
    tick();
    check("t3_pulses",  64'(vcnt), 64'd2);
    check("t3_mem_req", 64'(bus.mem_req), 64'd0);

    // Back-to-back: next request in the cycle of the last sram_valid
    vcnt = 0;
    send(32'h8000_0080);
    n = 0;
    while (!(bus.sram_valid && bus.sram_ready) && n < 40) begin
      tick();
      n++;
    end
    check("t4_last_beat_seen", 64'(n < 40), 64'd1);
    send(32'h1234_567C);
    check("t4_mem_req_new",  64'(bus.mem_req), 64'd1);
    check("t4_mem_addr_new", 64'(bus.mem_addr), 64'h1234_5670);
    wait_idle("t4_done");
    tick();
    check("t4_pulses", 64'(vcnt), 64'd4);

    // Reset mid-burst, with a stray response arriving afterwards
    rdly = 3;
    send(32'h4000_0000);
    tick();
    reset = 1'b1;
    #1;
    check("t5_ready",    64'(bus.sram_ready), 64'd1);
    check("t5_valid",    64'(bus.sram_valid), 64'd0);
    check("t5_mem_req",  64'(bus.mem_req), 64'd0);
    check("t5_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("t5_rdata",    bus.sram_rdata, 64'd0);
    exp_addr.delete();
    exp_data.delete();
    vcnt = 0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t5_no_valid", 64'(bus.sram_valid), 64'd0);
    end
    check("t5_ready_after", 64'(bus.sram_ready), 64'd1);
    check("t5_pulses",      64'(vcnt), 64'd0);
    rdly = 0;

    // Request ignored while waiting for responses
    rdly = 4;
    vcnt = 0;
    send(32'h8000_0100);
    tick();
    tick();
    check("t6_wait_mem_req", 64'(bus.mem_req), 64'd0);
    bus.sram_req  = 1'b1;
    bus.sram_addr = 32'hDEAD_0000;
    tick();
    check("t6_busy_mem_req_a", 64'(bus.mem_req), 64'd0);
    check("t6_busy_ready",     64'(bus.sram_ready), 64'd0);
    bus.sram_req = 1'b0;
    tick();
    check("t6_busy_mem_req_b", 64'(bus.mem_req), 64'd0);
    bus.sram_req = 1'b1;
    tick();
    check("t6_busy_mem_req_c", 64'(bus.mem_req), 64'd0);
    bus.sram_req  = 1'b0;
    bus.sram_addr = '0;
    wait_idle("t6_done");
    repeat (3) tick();
    check("t6_pulses",       64'(vcnt), 64'd2);
    check("t6_idle_mem_req", 64'(bus.mem_req), 64'd0);
    rdly = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
